// File: rtl/poly_note_player_if.sv
// Controller/mixer-facing signal bundle for poly_note_player.
// master = song controller + codec side, slave = the note player.
interface poly_note_player_if;
  logic               play_enable;
  logic               activate;
  logic [5:0]         note_to_load;
  logic [5:0]         duration;
  logic               load_new_note;
  logic               beat;
  logic               generate_next_sample;
  logic               note_done1;
  logic               note_done2;
  logic               note_done3;
  logic signed [17:0] sample_out1;
  logic signed [17:0] sample_out2;
  logic signed [17:0] sample_out3;
  logic               sample_ready1;
  logic               sample_ready2;
  logic               sample_ready3;

  modport master (
    output play_enable, activate, note_to_load, duration, load_new_note,
           beat, generate_next_sample,
    input  note_done1, note_done2, note_done3,
           sample_out1, sample_out2, sample_out3,
           sample_ready1, sample_ready2, sample_ready3
  );

  modport slave (
    input  play_enable, activate, note_to_load, duration, load_new_note,
           beat, generate_next_sample,
    output note_done1, note_done2, note_done3,
           sample_out1, sample_out2, sample_out3,
           sample_ready1, sample_ready2, sample_ready3
  );
endinterface

// File: rtl/poly_note_player.sv
// Three-voice triangle-wave note player with per-voice beat-counted durations.
// Optional NOTE_PLAYER_INTERNAL_BEAT_EN replaces the beat port with an internal tick.
module poly_note_player #(
  parameter int NUM_VOICES = 3,
  parameter int PHASE_W    = 20,
  parameter int DATA_W     = 18,
  parameter int BEAT_STOP  = 1000
) (
  input logic               clk,
  input logic               reset,
  poly_note_player_if.slave bus
);

  logic                      busy   [NUM_VOICES];
  logic [5:0]                note   [NUM_VOICES];
  logic [5:0]                cnt    [NUM_VOICES];
  logic [PHASE_W-1:0]        step   [NUM_VOICES];
  logic [PHASE_W-1:0]        phase  [NUM_VOICES];
  logic [PHASE_W-1:0]        phase_nxt [NUM_VOICES];
  logic signed [DATA_W-1:0]  sample_p1 [NUM_VOICES];
  logic                      vld_p1 [NUM_VOICES];
  logic                      done_p1 [NUM_VOICES];

  logic       run;
  logic       beat_tick;
  logic       free_hit;
  logic [1:0] free_idx;
  logic       load_ok;

  function automatic logic [PHASE_W-1:0] step_of(input logic [5:0] n);
    logic [6:0]  s;
    logic [3:0]  idx;
    logic [2:0]  oct;
    logic [14:0] base;
    s   = {1'b0, n} + 7'd8;
    idx = 4'(s % 7'd12);
    oct = 3'(s / 7'd12);
    case (idx)
      4'd0:    base = 15'd11430;
      4'd1:    base = 15'd12110;
      4'd2:    base = 15'd12830;
      4'd3:    base = 15'd13593;
      4'd4:    base = 15'd14401;
      4'd5:    base = 15'd15258;
      4'd6:    base = 15'd16165;
      4'd7:    base = 15'd17126;
      4'd8:    base = 15'd18145;
      4'd9:    base = 15'd19224;
      4'd10:   base = 15'd20367;
      default: base = 15'd21578;
    endcase
    if (n == 6'd0) return '0;
    return PHASE_W'(base >> (3'd5 - oct));
  endfunction

  // Fold the upper half of the phase back down, then centre on zero.
  function automatic logic signed [DATA_W-1:0] wave(input logic [PHASE_W-1:0] p);
    logic [16:0] t;
    t = p[19] ? ~p[18:2] : p[18:2];
    return $signed({1'b0, t}) - 18'sd65536;
  endfunction

`ifdef NOTE_PLAYER_INTERNAL_BEAT_EN
  localparam int BEAT_W = $clog2(BEAT_STOP);
  logic [BEAT_W-1:0] beat_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      beat_cnt <= '0;
    else if (bus.activate)
      beat_cnt <= (beat_cnt == BEAT_W'(BEAT_STOP - 1)) ? '0 : beat_cnt + 1'b1;
  end
  assign beat_tick = bus.activate && (beat_cnt == BEAT_W'(BEAT_STOP - 1));
`else
  assign beat_tick = bus.beat;
`endif

  assign run = bus.play_enable & bus.activate;

  // Voices freeing on this edge are still busy here, so they are not picked.
  always_comb begin
    free_hit = 1'b0;
    free_idx = 2'd0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!busy[v]) begin
        free_hit = 1'b1;
        free_idx = v[1:0];
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) phase_nxt[v] = phase[v] + step[v];
  end

  assign load_ok = bus.load_new_note & bus.activate & (bus.duration != 6'd0) & free_hit;

  // Stage p0 -> p1: voice state update and registered sample/ready/done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        busy[v]      <= 1'b0;
        note[v]      <= '0;
        cnt[v]       <= '0;
        step[v]      <= '0;
        phase[v]     <= '0;
        sample_p1[v] <= '0;
        vld_p1[v]    <= 1'b0;
        done_p1[v]   <= 1'b0;
      end
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        vld_p1[v]  <= 1'b0;
        done_p1[v] <= 1'b0;
        if (busy[v] && beat_tick && run) begin
          cnt[v] <= cnt[v] - 6'd1;
          if (cnt[v] == 6'd1) begin
            busy[v]    <= 1'b0;
            done_p1[v] <= 1'b1;
          end
        end
        if (bus.generate_next_sample && run) begin
          vld_p1[v] <= 1'b1;
          if (busy[v] && note[v] != 6'd0) begin
            phase[v]     <= phase_nxt[v];
            sample_p1[v] <= wave(phase_nxt[v]);
          end else begin
            sample_p1[v] <= '0;
          end
        end
        if (load_ok && free_idx == v[1:0]) begin
          busy[v]  <= 1'b1;
          note[v]  <= bus.note_to_load;
          cnt[v]   <= bus.duration;
          step[v]  <= step_of(bus.note_to_load);
          phase[v] <= '0;
        end
      end
    end
  end

  assign bus.note_done1    = done_p1[0];
  assign bus.note_done2    = done_p1[1];
  assign bus.note_done3    = done_p1[2];
  assign bus.sample_out1   = sample_p1[0];
  assign bus.sample_out2   = sample_p1[1];
  assign bus.sample_out3   = sample_p1[2];
  assign bus.sample_ready1 = vld_p1[0];
  assign bus.sample_ready2 = vld_p1[1];
  assign bus.sample_ready3 = vld_p1[2];

endmodule

// File: tb/tb_poly_note_player.sv
// Randomised and directed bench for poly_note_player against a voice-level reference model.
module tb_poly_note_player;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  poly_note_player_if bus ();
  poly_note_player dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  int BASE[12] = '{11430, 12110, 12830, 13593, 14401, 15258,
                   16165, 17126, 18145, 19224, 20367, 21578};

  int m_busy[3], m_note[3], m_rem[3], m_phase[3];
  int m_samp[3], m_done[3], m_rdy[3];
  int done1_seen;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_step(int n);
    if (n == 0) return 0;
    return BASE[(n + 8) % 12] / (1 << (5 - (n + 8) / 12));
  endfunction

  function automatic int ref_wave(int p);
    int t;
    t = (p < 524288) ? p / 4 : (1048575 - p) / 4;
    return t - 65536;
  endfunction

  function automatic void model_clear();
    for (int v = 0; v < 3; v++) begin
      m_busy[v] = 0; m_note[v] = 0; m_rem[v] = 0; m_phase[v] = 0;
      m_samp[v] = 0; m_done[v] = 0; m_rdy[v] = 0;
    end
  endfunction

  // One clock edge of the player, straight from the behavioural rules.
  function automatic void model_edge();
    int was_busy[3];
    int run;
    run = bus.play_enable && bus.activate;
    for (int v = 0; v < 3; v++) begin
      was_busy[v] = m_busy[v];
      m_done[v] = 0;
      m_rdy[v] = 0;
    end
    for (int v = 0; v < 3; v++) begin
      if (was_busy[v] && bus.beat && run) begin
        m_rem[v]--;
        if (m_rem[v] == 0) begin m_busy[v] = 0; m_done[v] = 1; end
      end
      if (bus.generate_next_sample && run) begin
        m_rdy[v] = 1;
        if (was_busy[v] && m_note[v] != 0) begin
          m_phase[v] = (m_phase[v] + ref_step(m_note[v])) % 1048576;
          m_samp[v] = ref_wave(m_phase[v]);
        end else m_samp[v] = 0;
      end
    end
    if (bus.load_new_note && bus.activate && bus.duration != 0) begin
      for (int v = 0; v < 3; v++) begin
        if (!was_busy[v]) begin
          m_busy[v] = 1; m_note[v] = bus.note_to_load;
          m_rem[v] = bus.duration; m_phase[v] = 0;
          break;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("note_done1", bus.note_done1, m_done[0]);
    check("note_done2", bus.note_done2, m_done[1]);
    check("note_done3", bus.note_done3, m_done[2]);
    check("sample_ready1", bus.sample_ready1, m_rdy[0]);
    check("sample_ready2", bus.sample_ready2, m_rdy[1]);
    check("sample_ready3", bus.sample_ready3, m_rdy[2]);
    check("sample_out1", int'(bus.sample_out1), m_samp[0]);
    check("sample_out2", int'(bus.sample_out2), m_samp[1]);
    check("sample_out3", int'(bus.sample_out3), m_samp[2]);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_clear(); else model_edge();
    #1;
    if (bus.note_done1) done1_seen++;
    compare_all();
  endtask

  task automatic idle_inputs();
    bus.load_new_note = 0; bus.beat = 0; bus.generate_next_sample = 0;
  endtask

  task automatic load(input int n, input int d);
    bus.note_to_load = 6'(n); bus.duration = 6'(d); bus.load_new_note = 1;
    tick();
    bus.load_new_note = 0;
  endtask

  task automatic gen_once();
    bus.generate_next_sample = 1;
    tick();
    bus.generate_next_sample = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    #1;
    model_clear();
    compare_all();
    repeat (2) tick();
    reset = 1;
  endtask

  initial begin
    bus.play_enable = 1; bus.activate = 1;
    bus.note_to_load = 0; bus.duration = 0;
    idle_inputs();
    model_clear();
    done1_seen = 0;
    #2;
    do_reset();

    // Single note: sample values and duration countdown.
    load(44, 6);
    gen_once();
    check("first_sample", int'(bus.sample_out1), -63736);
    check("first_ready", bus.sample_ready1, 1);
    gen_once();
    check("second_sample", int'(bus.sample_out1), -61936);
    for (int c = 0; c < 40; c++) begin
      bus.beat = (c % 5 == 4);
      tick();
    end
    bus.beat = 0;
    check("done1_count", done1_seen, 1);

    // Fill all three voices; fourth load dropped; rest voice outputs 0.
    do_reset();
    load(44, 20); load(49, 20); load(0, 20); load(10, 20);
    for (int c = 0; c < 6; c++) begin
      gen_once();
      check("rest_voice", int'(bus.sample_out3), 0);
    end

    // Pause via play_enable, then via activate, with requests and beats arriving.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) bus.play_enable = 0; else bus.activate = 0;
      for (int c = 0; c < 100; c++) begin
        bus.beat = (c % 3 == 0);
        bus.generate_next_sample = (c % 2 == 0);
        bus.load_new_note = (c == 50);
        tick();
      end
      idle_inputs();
      bus.play_enable = 1; bus.activate = 1;
      for (int c = 0; c < 30; c++) begin
        bus.beat = (c % 4 == 0);
        bus.generate_next_sample = (c % 2 == 1);
        tick();
      end
      idle_inputs();
    end

    // Reset in the middle of a note, then a fresh load lands on voice 1.
    load(44, 10);
    repeat (3) gen_once();
    @(negedge clk);
    do_reset();
    check("reset_out1", int'(bus.sample_out1), 0);
    load(30, 3);
    gen_once();
    check("after_reset_ready1", bus.sample_ready1, 1);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      bus.load_new_note = ($urandom_range(0, 9) == 0);
      bus.note_to_load  = 6'($urandom_range(0, 63));
      bus.duration      = 6'($urandom_range(0, 12));
      bus.beat          = ($urandom_range(0, 4) == 0);
      bus.generate_next_sample = ($urandom_range(0, 2) == 0);
      bus.play_enable   = ($urandom_range(0, 19) != 0);
      bus.activate      = ($urandom_range(0, 29) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
